ram_sync: RTL and testbench
===========================

# ram_sync

Parametrised synchronous scratch RAM: the successor to the CPU's 16×8 asynchronous-read RAM. It adds a registered read on two ports, per-byte write enables, write-first forwarding between ports, and a hardware clear sweep after reset. It sits on the CPU data bus. Read data is zero whenever no read was issued, so outputs can be OR-combined onto a shared bus.

## Interface
Parameters:
- WIDTH, 8, data width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; need not be a power of two.
- AW, $clog2(DEPTH), address width.
- CLEAR_ON_RESET, 1, 1 = sweep memory to CLEAR_VALUE after reset; 0 = no sweep, contents undefined.
- CLEAR_VALUE, 0, WIDTH-bit fill word.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN0  in  1  port 0 request.
- WE0  in  1  port 0 write (1) / read (0).
- BE0  in  WIDTH/8  port 0 byte enables; bit i covers Di0[8i+7:8i].
- A0  in  AW  port 0 address.
- Di0  in  WIDTH  port 0 write data.
- Do0  out  WIDTH  port 0 registered read data.
- EN1  in  1  port 1 read request (read-only port).
- A1  in  AW  port 1 address.
- Do1  out  WIDTH  port 1 registered read data.
- BUSY  out  1  clear sweep in progress; requests are ignored while high.

## Operation
- FSM states are CLEAR and READY.
- While RST_N=0:
  - state = CLEAR if CLEAR_ON_RESET, else READY.
  - sweep counter = 0; Do0 = Do1 = 0; BUSY = CLEAR_ON_RESET.
  - Memory contents are not touched asynchronously.
- CLEAR: each cycle writes CLEAR_VALUE (all bytes) to the address held in the sweep counter, then increments the counter. On the cycle that writes DEPTH-1, the FSM moves to READY and BUSY falls.
- While BUSY=1, EN0/EN1 are ignored: no write occurs and Do0/Do1 stay 0.
- READY, port 0 write (EN0&WE0): every byte i with BE0[i]=1 takes Di0 byte i. The other bytes are unchanged. BE0=0 writes nothing.
- READY, port 0 read (EN0&~WE0): Do0 takes mem[A0] on the next edge.
- READY, port 1 read (EN1): Do1 takes mem[A1] on the next edge.
- Any port that issues no read in a cycle has Do = 0 on the next edge (zero-when-idle bus rule).
- Write-first forwarding: a port 0 write and a port 1 read to the same address in the same cycle give Do1 = the merged word. Enabled bytes come from Di0; the rest are the old contents.
- Out-of-range address (≥ DEPTH, only possible when DEPTH is not a power of two): writes are dropped and reads return 0.
- Reset asserted mid-sweep aborts the sweep. The sweep restarts from address 0 after release.

## Timing
- Read latency is 1 cycle. A request at edge n gives data valid after edge n+1, held until the next edge.
- A write at edge n is visible to a read issued at edge n+1.
- The clear sweep takes exactly DEPTH cycles after the first rising edge with RST_N=1. BUSY is high for those DEPTH cycles.
- No combinational path runs from any input to Do0, Do1 or BUSY.
- Reset values: Do0=0, Do1=0, BUSY=CLEAR_ON_RESET.

## Structure
- Package ram_pkg holds:
  - the FSM state enum (RAM_CLEAR, RAM_READY);
  - the function byte_merge(old, new, be), shared by the write path and the forwarding path.
- Sub-module ram_clear_seq holds the FSM and sweep counter. It outputs BUSY, the sweep address and the sweep write strobe into the top-level write mux.
- The memory array and the read registers stay in ram_sync. Use a plain reg array so synthesis can infer a RAM or flop block.

## Test plan
- Reset release, DEPTH=16, CLEAR_VALUE=8'hA5 → BUSY=1 for exactly 16 cycles. Reads of every address afterwards return 8'hA5. A write attempted while BUSY (A0=3, Di0=8'h11) is dropped, so mem[3] still reads 8'hA5.
- WIDTH=16, write A0=5 Di0=16'h1234 BE0=2'b11, then A0=5 Di0=16'hABCD BE0=2'b01 → a read of 5 returns 16'h12CD one cycle after the request.
- Same-cycle port 0 write (A0=7, Di0=8'h3C) and port 1 read (A1=7) → Do1=8'h3C on the next edge. A port 1 read of 8 in the same cycle returns the old mem[8].
- Read A0=2 in one cycle, then EN0=0 → Do0 shows mem[2] for one cycle, then 0. Back-to-back reads of 2 and 4 give consecutive words with no bubble.
- DEPTH=12, write then read A0=13 → write dropped, Do0=0, memory unchanged.
- RST_N pulsed low at sweep cycle 6 → Do0/Do1 go to 0 immediately. BUSY stays high through reset and for 16 cycles after release; the full sweep is verified.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the synchronous scratch RAM.
package ram_pkg;

  typedef enum logic {RAM_CLEAR, RAM_READY} ram_state_e;

  // Widest word byte_merge handles; callers widen their operands and cast the result back.
  localparam int RAM_MAX_W  = 256;
  localparam int RAM_MAX_BE = RAM_MAX_W / 8;

  function automatic logic [RAM_MAX_W-1:0] byte_merge(
    input logic [RAM_MAX_W-1:0]  old_w,
    input logic [RAM_MAX_W-1:0]  new_w,
    input logic [RAM_MAX_BE-1:0] be
  );
    logic [RAM_MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < RAM_MAX_BE; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then hands the array to the ports.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int AW             = $clog2(DEPTH),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          busy_o,
  output logic [AW-1:0] sweep_addr_o,
  output logic          sweep_we_o
);

  localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
  localparam ram_state_e    RST_STATE = CLEAR_ON_RESET ? RAM_CLEAR : RAM_READY;

  ram_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sweep_we_o = 1'b0;
    case (state_q)
      RAM_CLEAR: begin
        sweep_we_o = 1'b1;
        if (cnt_q == LAST) begin
          state_d = RAM_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_q == RAM_CLEAR);
  assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/ram_sync.sv
// Synchronous scratch RAM: one R/W port, one read port, registered zero-when-idle outputs.
module ram_sync
  import ram_pkg::*;
#(
  parameter int               WIDTH          = 8,
  parameter int               DEPTH          = 16,
  parameter int               AW             = $clog2(DEPTH),
  parameter bit               CLEAR_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN0,
  input  logic               WE0,
  input  logic [WIDTH/8-1:0] BE0,
  input  logic [AW-1:0]      A0,
  input  logic [WIDTH-1:0]   Di0,
  output logic [WIDTH-1:0]   Do0,
  input  logic               EN1,
  input  logic [AW-1:0]      A1,
  output logic [WIDTH-1:0]   Do1,
  output logic               BUSY
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             busy, sweep_we;
  logic [AW-1:0]    sweep_addr;
  logic             a0_ok, a1_ok, wr0, rd0, rd1;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] do0_q, do0_d, do1_q, do1_d;

  ram_clear_seq #(
    .DEPTH          (DEPTH),
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk_i        (CLK),
    .rst_ni       (RST_N),
    .busy_o       (busy),
    .sweep_addr_o (sweep_addr),
    .sweep_we_o   (sweep_we)
  );

  // Addresses past DEPTH exist only when DEPTH is not a power of two.
  if (DEPTH == (1 << AW)) begin : g_pow2
    assign a0_ok = 1'b1;
    assign a1_ok = 1'b1;
  end else begin : g_npow2
    localparam logic [AW-1:0] LIM = AW'(DEPTH);
    assign a0_ok = (A0 < LIM);
    assign a1_ok = (A1 < LIM);
  end

  assign wr0 = !busy && EN0 &&  WE0 && a0_ok;
  assign rd0 = !busy && EN0 && !WE0 && a0_ok;
  assign rd1 = !busy && EN1 && a1_ok;

  // Same merged word feeds the array and the port-1 bypass.
  assign wr_word = WIDTH'(byte_merge(RAM_MAX_W'(mem[A0]), RAM_MAX_W'(Di0), RAM_MAX_BE'(BE0)));

  always_comb begin
    do0_d = '0;
    do1_d = '0;
    if (rd0) do0_d = mem[A0];
    if (rd1) do1_d = (wr0 && (A0 == A1)) ? wr_word : mem[A1];
  end

  always_ff @(posedge CLK) begin
    if (sweep_we)
      mem[sweep_addr] <= CLEAR_VALUE;
    else if (wr0)
      mem[A0] <= wr_word;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      do0_q <= '0;
      do1_q <= '0;
    end else begin
      do0_q <= do0_d;
      do1_q <= do1_d;
    end
  end

  assign Do0  = do0_q;
  assign Do1  = do1_q;
  assign BUSY = busy;

endmodule

// File: tb/tb_ram_sync.sv
// Bench for ram_sync: a 16x16 instance and an 8-bit 12-deep instance against an array model.
module tb_ram_sync;

  localparam int          DA  = 16;
  localparam int          DB  = 12;
  localparam logic [15:0] CVA = 16'hA5A5;
  localparam logic [7:0]  CVB = 8'hA5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        en0a, we0a, en1a, busya;
  logic [1:0]  be0a;
  logic [3:0]  a0a, a1a;
  logic [15:0] di0a, do0a, do1a;

  logic        en0b, we0b, en1b, busyb;
  logic [0:0]  be0b;
  logic [3:0]  a0b, a1b;
  logic [7:0]  di0b, do0b, do1b;

  ram_sync #(.WIDTH(16), .DEPTH(DA), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CVA)) u_a (
    .CLK(clk), .RST_N(rst_n), .EN0(en0a), .WE0(we0a), .BE0(be0a), .A0(a0a), .Di0(di0a),
    .Do0(do0a), .EN1(en1a), .A1(a1a), .Do1(do1a), .BUSY(busya)
  );

  ram_sync #(.WIDTH(8), .DEPTH(DB), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CVB)) u_b (
    .CLK(clk), .RST_N(rst_n), .EN0(en0b), .WE0(we0b), .BE0(be0b), .A0(a0b), .Di0(di0b),
    .Do0(do0b), .EN1(en1b), .A1(a1b), .Do1(do1b), .BUSY(busyb)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] ma [DA];
  logic [7:0]  mb [DB];
  int          left_a = 0;
  int          left_b = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en0a = 1'b0; we0a = 1'b0; be0a = 2'b00; a0a = 4'd0; a1a = 4'd0; di0a = 16'h0; en1a = 1'b0;
    en0b = 1'b0; we0b = 1'b0; be0b = 1'b0;  a0b = 4'd0; a1b = 4'd0; di0b = 8'h0;  en1b = 1'b0;
  endtask

  task automatic rnd();
    en0a = 1'($urandom_range(0, 1)); we0a = 1'($urandom_range(0, 1)); be0a = 2'($urandom);
    a0a  = 4'($urandom); a1a = 4'($urandom); di0a = 16'($urandom); en1a = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) a1a = a0a;
    en0b = 1'($urandom_range(0, 1)); we0b = 1'($urandom_range(0, 1)); be0b = 1'($urandom);
    a0b  = 4'($urandom); a1b = 4'($urandom); di0b = 8'($urandom); en1b = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) a1b = a0b;
  endtask

  // One clock: model the requests currently on the inputs, clock, then compare all outputs.
  task automatic cyc(input string tag);
    logic [15:0] ea0, ea1, w;
    logic [7:0]  eb0, eb1;
    ea0 = '0; ea1 = '0; eb0 = '0; eb1 = '0;
    if (left_a == 0) begin
      if (en0a && we0a) begin
        w = ma[a0a];
        if (be0a[0]) w[7:0]  = di0a[7:0];
        if (be0a[1]) w[15:8] = di0a[15:8];
        ma[a0a] = w;
      end
      if (en0a && !we0a) ea0 = ma[a0a];
      if (en1a)          ea1 = ma[a1a];
    end else left_a--;
    if (left_b == 0) begin
      if (en0b && we0b && a0b < DB && be0b[0]) mb[a0b] = di0b;
      if (en0b && !we0b && a0b < DB) eb0 = mb[a0b];
      if (en1b && a1b < DB)          eb1 = mb[a1b];
    end else left_b--;
    @(posedge clk); #1;
    chk({tag, " do0a"},  do0a, ea0);
    chk({tag, " do1a"},  do1a, ea1);
    chk({tag, " busya"}, {15'd0, busya}, {15'd0, left_a > 0});
    chk({tag, " do0b"},  {8'd0, do0b}, {8'd0, eb0});
    chk({tag, " do1b"},  {8'd0, do1b}, {8'd0, eb1});
    chk({tag, " busyb"}, {15'd0, busyb}, {15'd0, left_b > 0});
  endtask

  task automatic reset_pulse(input int ncyc);
    rst_n = 1'b0;
    #1;
    chk("rst do0a", do0a, 16'h0);  chk("rst do1a", do1a, 16'h0);
    chk("rst do0b", {8'd0, do0b}, 16'h0); chk("rst do1b", {8'd0, do1b}, 16'h0);
    chk("rst busya", {15'd0, busya}, 16'd1); chk("rst busyb", {15'd0, busyb}, 16'd1);
    repeat (ncyc) @(posedge clk);
    #1;
    chk("rst hold busya", {15'd0, busya}, 16'd1);
    chk("rst hold do0a", do0a, 16'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    left_a = DA;
    left_b = DB;
    foreach (ma[i]) ma[i] = CVA;
    foreach (mb[i]) mb[i] = CVB;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      idle();
      en0a = 1'b1; a0a = 4'(i); en1a = 1'b1; a1a = 4'(15 - i);
      en0b = 1'b1; a0b = 4'(i); en1b = 1'b1; a1b = 4'(15 - i);
      cyc(tag);
    end
  endtask

  initial begin
    idle();
    #2;
    reset_pulse(3);

    // Write attempted in the first sweep cycle must be dropped.
    en0a = 1'b1; we0a = 1'b1; a0a = 4'd3; di0a = 16'h1111; be0a = 2'b11;
    en0b = 1'b1; we0b = 1'b1; a0b = 4'd3; di0b = 8'h11;    be0b = 1'b1;
    cyc("busy_wr");
    for (int i = 1; i < DA; i++) begin
      idle();
      cyc("sweep");
    end
    chk("sweep done a", {15'd0, busya}, 16'd0);
    read_all("clr");
    idle(); en0a = 1'b1; a0a = 4'd3; en0b = 1'b1; a0b = 4'd3;
    cyc("rd3");
    chk("mem3 a", do0a, CVA);
    chk("mem3 b", {8'd0, do0b}, {8'd0, CVB});

    // Partial byte write merge.
    idle(); en0a = 1'b1; we0a = 1'b1; a0a = 4'd5; di0a = 16'h1234; be0a = 2'b11;
    cyc("wr5");
    di0a = 16'hABCD; be0a = 2'b01;
    cyc("wr5be");
    we0a = 1'b0;
    cyc("rd5");
    chk("merge", do0a, 16'h12CD);

    // Write-first forwarding to the read port, and an unrelated same-cycle read.
    idle();
    en0a = 1'b1; we0a = 1'b1; a0a = 4'd7; di0a = 16'h003C; be0a = 2'b11; en1a = 1'b1; a1a = 4'd7;
    en0b = 1'b1; we0b = 1'b1; a0b = 4'd7; di0b = 8'h3C;    be0b = 1'b1;  en1b = 1'b1; a1b = 4'd8;
    cyc("fwd");
    chk("fwd a", do1a, 16'h003C);
    chk("old b", {8'd0, do1b}, {8'd0, CVB});
    idle(); en1b = 1'b1; a1b = 4'd7;
    cyc("fwd_b_after");
    chk("wr7 b", {8'd0, do1b}, 16'h003C);

    // Single read then idle, and back-to-back reads.
    idle(); en0a = 1'b1; we0a = 1'b1; be0a = 2'b11; a0a = 4'd2; di0a = 16'h0202;
    cyc("wr2");
    a0a = 4'd4; di0a = 16'h0404;
    cyc("wr4");
    idle(); en0a = 1'b1; a0a = 4'd2;
    cyc("rd2");
    chk("rd2 val", do0a, 16'h0202);
    idle();
    cyc("idle0");
    chk("idle zero", do0a, 16'h0);
    en0a = 1'b1; a0a = 4'd2;
    cyc("b2b2");
    a0a = 4'd4;
    cyc("b2b4");
    chk("b2b second", do0a, 16'h0404);

    // Out-of-range address on the 12-deep instance.
    idle(); en0b = 1'b1; we0b = 1'b1; a0b = 4'd13; di0b = 8'h5A; be0b = 1'b1;
    cyc("oor_wr");
    we0b = 1'b0; en1b = 1'b1; a1b = 4'd13;
    cyc("oor_rd");
    chk("oor do0", {8'd0, do0b}, 16'h0);
    chk("oor do1", {8'd0, do1b}, 16'h0);
    read_all("oor_chk");

    repeat (300) begin
      rnd();
      cyc("rand");
    end
    read_all("rand_chk");

    // Reset from READY with reads in flight, then abort a sweep part way through.
    idle(); en0a = 1'b1; a0a = 4'd5; en1a = 1'b1; a1a = 4'd7; en0b = 1'b1; a0b = 4'd7;
    cyc("pre_rst");
    idle();
    reset_pulse(2);
    for (int i = 0; i < 6; i++) cyc("sweep2");
    reset_pulse(1);
    for (int i = 0; i < DA; i++) cyc("sweep3");
    chk("sweep3 done a", {15'd0, busya}, 16'd0);
    chk("sweep3 done b", {15'd0, busyb}, 16'd0);
    read_all("clr3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
